// File: rtl/uart_pkg.sv
// uart_pkg: shared UART byte type, LF constant, default RX queue depth and MMIO status layout
`ifndef UART_DATA_WIDTH
`define UART_DATA_WIDTH 8
`endif
package uart_pkg;
  localparam int UART_DATA_WIDTH = `UART_DATA_WIDTH;
  localparam int UART_RX_FIFO_DEPTH = 16;
  typedef logic [UART_DATA_WIDTH-1:0] uart_byte_t;
  localparam uart_byte_t UART_LF = uart_byte_t'(8'h0A);
  typedef struct packed {
    logic line_avail;
    logic full;
    logic frame_err;
    logic overflow;
    logic rd_valid;
  } uart_status_t;
endpackage

// File: rtl/uart_fifo_mem.sv
// uart_fifo_mem: reset-free byte storage with one synchronous write port and one combinational read port
module uart_fifo_mem #(
  parameter int DEPTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  // write the accepted byte into its slot
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end
  assign rdata = mem[raddr];
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receive queue with show-ahead pop port and sticky flags; UART_RX_LINE_DETECT_EN enables LF line counting
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = UART_RX_FIFO_DEPTH,
  parameter int DATA_WIDTH = UART_DATA_WIDTH,
  parameter int CNT_WIDTH = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] uart_rx_data,
  input  logic                  uart_rx_valid,
  input  logic                  uart_rx_err,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  input  logic                  clr_flags,
  output logic [CNT_WIDTH-1:0]  count,
  output logic                  full,
  output logic                  overflow,
  output logic                  frame_err,
  output logic [CNT_WIDTH-1:0]  line_count,
  output logic                  line_avail
);
  localparam int AW = $clog2(DEPTH);
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [DATA_WIDTH-1:0] mem_data;
  logic push, pop, drop, err_in;
  assign full = count == CNT_WIDTH'(DEPTH);
  assign rd_valid = count != '0;
  assign pop = rd_valid && rd_ready;
  assign push = uart_rx_valid && !uart_rx_err && (!full || pop);
  assign drop = uart_rx_valid && !uart_rx_err && full && !pop;
  assign err_in = uart_rx_valid && uart_rx_err;
  assign rd_data = rd_valid ? mem_data : '0;
  uart_fifo_mem #(.DEPTH(DEPTH), .DATA_WIDTH(DATA_WIDTH), .AW(AW)) u_mem (
    .clk(clk),
    .we(push),
    .waddr(wr_ptr),
    .wdata(uart_rx_data),
    .raddr(rd_ptr),
    .rdata(mem_data)
  );
  // pointers wrap naturally; count disambiguates full from empty
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= push ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr <= pop ? rd_ptr + AW'(1) : rd_ptr;
      count <= count + CNT_WIDTH'(push) - CNT_WIDTH'(pop);
    end
  end
  // sticky flags: a set event in the same cycle as clr_flags wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      overflow <= drop | (overflow & ~clr_flags);
      frame_err <= err_in | (frame_err & ~clr_flags);
    end
  end
`ifdef UART_RX_LINE_DETECT_EN
  logic lf_in, lf_out;
  assign lf_in = push && uart_rx_data == DATA_WIDTH'(UART_LF);
  assign lf_out = pop && mem_data == DATA_WIDTH'(UART_LF);
  // count LF bytes resident in the queue; dropped bytes never reach lf_in
  always_ff @(posedge clk or posedge rst) begin
    if (rst) line_count <= '0;
    else line_count <= line_count + CNT_WIDTH'(lf_in) - CNT_WIDTH'(lf_out);
  end
  assign line_avail = line_count != '0;
`else
  assign line_count = '0;
  assign line_avail = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed self-checking bench for uart_rx_fifo (DEPTH 16)
module tb_uart_rx_fifo;
`ifdef UART_RX_LINE_DETECT_EN
  localparam bit LINE_EN = 1'b1;
`else
  localparam bit LINE_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] uart_rx_data = '0;
  logic uart_rx_valid = 1'b0;
  logic uart_rx_err = 1'b0;
  logic [7:0] rd_data;
  logic rd_valid;
  logic rd_ready = 1'b0;
  logic clr_flags = 1'b0;
  logic [4:0] count;
  logic full, overflow, frame_err;
  logic [4:0] line_count;
  logic line_avail;
  int checks = 0;
  int passed = 0;

  uart_rx_fifo #(.DEPTH(16), .DATA_WIDTH(8)) dut (
    .clk(clk),
    .rst(rst),
    .uart_rx_data(uart_rx_data),
    .uart_rx_valid(uart_rx_valid),
    .uart_rx_err(uart_rx_err),
    .rd_data(rd_data),
    .rd_valid(rd_valid),
    .rd_ready(rd_ready),
    .clr_flags(clr_flags),
    .count(count),
    .full(full),
    .overflow(overflow),
    .frame_err(frame_err),
    .line_count(line_count),
    .line_avail(line_avail)
  );

  always #5 clk = ~clk;

  task automatic strobe(input logic [7:0] d, input logic e);
    @(negedge clk);
    uart_rx_data = d;
    uart_rx_err = e;
    uart_rx_valid = 1'b1;
    @(negedge clk);
    uart_rx_valid = 1'b0;
    uart_rx_err = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    checks++; if (count !== 5'd0) $display("FAIL reset_count got %0d exp 0", count); else passed++;
    checks++; if (rd_valid !== 1'b0 || full !== 1'b0) $display("FAIL reset_valid_full got %b%b exp 00", rd_valid, full); else passed++;
    checks++; if (overflow !== 1'b0 || frame_err !== 1'b0) $display("FAIL reset_flags got %b%b exp 00", overflow, frame_err); else passed++;
    checks++; if (rd_data !== 8'h00) $display("FAIL reset_rd_data got %h exp 00", rd_data); else passed++;
    checks++; if (line_count !== 5'd0 || line_avail !== 1'b0) $display("FAIL reset_line got %0d/%b exp 0/0", line_count, line_avail); else passed++;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_push_three;
    logic [7:0] b [3];
    b[0] = 8'h41; b[1] = 8'h71; b[2] = 8'h0A;
    for (int i = 0; i < 3; i++) begin
      strobe(b[i], 1'b0);
      checks++; if (count !== 5'(i + 1)) $display("FAIL push_count%0d got %0d exp %0d", i, count, i + 1); else passed++;
      repeat (8) @(negedge clk);
    end
    checks++; if (rd_data !== 8'h41 || rd_valid !== 1'b1) $display("FAIL push_head got %h/%b exp 41/1", rd_data, rd_valid); else passed++;
    checks++; if (line_count !== 5'(LINE_EN) || line_avail !== LINE_EN) $display("FAIL push_line got %0d/%b exp %0d/%b", line_count, line_avail, LINE_EN, LINE_EN); else passed++;
  endtask

  task automatic test_pop_three;
    logic [7:0] b [3];
    b[0] = 8'h41; b[1] = 8'h71; b[2] = 8'h0A;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (rd_data !== b[i]) $display("FAIL pop_data%0d got %h exp %h", i, rd_data, b[i]); else passed++;
      rd_ready = 1'b1;
      @(negedge clk);
      rd_ready = 1'b0;
    end
    checks++; if (rd_valid !== 1'b0 || count !== 5'd0) $display("FAIL pop_empty got %b/%0d exp 0/0", rd_valid, count); else passed++;
    checks++; if (rd_data !== 8'h00 || line_avail !== 1'b0) $display("FAIL pop_zero got %h/%b exp 00/0", rd_data, line_avail); else passed++;
    rd_ready = 1'b1;
    repeat (3) @(negedge clk);
    rd_ready = 1'b0;
    checks++; if (count !== 5'd0 || rd_valid !== 1'b0) $display("FAIL underflow got %0d/%b exp 0/0", count, rd_valid); else passed++;
    strobe(8'h33, 1'b0);
    checks++; if (rd_data !== 8'h33 || count !== 5'd1) $display("FAIL after_underflow got %h/%0d exp 33/1", rd_data, count); else passed++;
    rd_ready = 1'b1;
    @(negedge clk);
    rd_ready = 1'b0;
  endtask

  task automatic test_overflow_and_full_swap;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      uart_rx_data = 8'(i);
      uart_rx_valid = 1'b1;
      if (i == 16) begin
        checks++; if (full !== 1'b1 || overflow !== 1'b0) $display("FAIL pre_drop got %b/%b exp 1/0", full, overflow); else passed++;
      end
    end
    @(negedge clk);
    uart_rx_valid = 1'b0;
    checks++; if (full !== 1'b1 || overflow !== 1'b1 || count !== 5'd16) $display("FAIL overflow got %b/%b/%0d exp 1/1/16", full, overflow, count); else passed++;
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
    checks++; if (overflow !== 1'b0) $display("FAIL ovf_clear got %b exp 0", overflow); else passed++;
    checks++; if (rd_data !== 8'h00) $display("FAIL swap_head got %h exp 00", rd_data); else passed++;
    uart_rx_data = 8'h55;
    uart_rx_valid = 1'b1;
    rd_ready = 1'b1;
    @(negedge clk);
    uart_rx_valid = 1'b0;
    rd_ready = 1'b0;
    checks++; if (overflow !== 1'b0 || count !== 5'd16 || full !== 1'b1) $display("FAIL swap got %b/%0d/%b exp 0/16/1", overflow, count, full); else passed++;
    rd_ready = 1'b1;
    for (int i = 1; i < 17; i++) begin
      logic [7:0] e;
      e = (i == 16) ? 8'h55 : 8'(i);
      checks++; if (rd_data !== e || count !== 5'(17 - i)) $display("FAIL drain%0d got %h/%0d exp %h/%0d", i, rd_data, count, e, 17 - i); else passed++;
      @(negedge clk);
    end
    rd_ready = 1'b0;
    checks++; if (count !== 5'd0 || rd_valid !== 1'b0) $display("FAIL drain_empty got %0d/%b exp 0/0", count, rd_valid); else passed++;
  endtask

  task automatic test_frame_err;
    strobe(8'h42, 1'b1);
    checks++; if (frame_err !== 1'b1 || count !== 5'd0 || rd_valid !== 1'b0) $display("FAIL ferr_set got %b/%0d/%b exp 1/0/0", frame_err, count, rd_valid); else passed++;
    @(negedge clk);
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
    checks++; if (frame_err !== 1'b0) $display("FAIL ferr_clear got %b exp 0", frame_err); else passed++;
    clr_flags = 1'b1;
    uart_rx_data = 8'h42;
    uart_rx_err = 1'b1;
    uart_rx_valid = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
    uart_rx_valid = 1'b0;
    uart_rx_err = 1'b0;
    checks++; if (frame_err !== 1'b1 || count !== 5'd0) $display("FAIL ferr_set_wins got %b/%0d exp 1/0", frame_err, count); else passed++;
  endtask

  task automatic test_async_reset;
    for (int i = 0; i < 5; i++) strobe(8'h0A, 1'b0);
    checks++; if (count !== 5'd5 || frame_err !== 1'b1) $display("FAIL pre_rst got %0d/%b exp 5/1", count, frame_err); else passed++;
    @(negedge clk);
    uart_rx_data = 8'h77;
    uart_rx_valid = 1'b1;
    #2 rst = 1'b1;
    #1;
    checks++; if (count !== 5'd0 || rd_valid !== 1'b0) $display("FAIL async_rst got %0d/%b exp 0/0", count, rd_valid); else passed++;
    checks++; if (frame_err !== 1'b0 || overflow !== 1'b0 || line_count !== 5'd0) $display("FAIL async_rst_flags got %b/%b/%0d exp 0/0/0", frame_err, overflow, line_count); else passed++;
    @(negedge clk);
    uart_rx_valid = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (count !== 5'd0 || rd_data !== 8'h00) $display("FAIL post_rst got %0d/%h exp 0/00", count, rd_data); else passed++;
  endtask

  initial begin
    test_reset;
    test_push_three;
    test_pop_three;
    test_overflow_and_full_swap;
    test_frame_err;
    test_async_reset;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive buffer directly downstream of uart_rx. It captures each byte that uart_rx_valid qualifies, queues it, and presents it to the JPU MMIO/load path through a valid/ready pop interface.
- Decouples the CPU polling rate from UART line rate. Keeps sticky overflow and framing-error flags that software can read and clear.

Parameters:
- DEPTH, 16, number of byte entries; power of 2, >= 2
- DATA_WIDTH, `UART_DATA_WIDTH (8), byte width; must match uart_rx
- CNT_WIDTH, $clog2(DEPTH+1), width of the occupancy count

Ports:
- clk  in  1  system clock, single domain
- rst  in  1  reset, asynchronous, active-high
- uart_rx_data  in  DATA_WIDTH  byte from uart_rx
- uart_rx_valid  in  1  single-cycle strobe from uart_rx
- uart_rx_err  in  1  framing error qualifier, valid with uart_rx_valid
- rd_data  out  DATA_WIDTH  head-of-queue byte (show-ahead)
- rd_valid  out  1  queue non-empty
- rd_ready  in  1  consumer pops the head when rd_valid && rd_ready
- clr_flags  in  1  one-cycle pulse that clears the sticky flags
- count  out  CNT_WIDTH  current occupancy, 0..DEPTH
- full  out  1  count == DEPTH
- overflow  out  1  sticky: a byte was dropped because the queue was full
- frame_err  out  1  sticky: a byte was received with uart_rx_err set
- line_count  out  CNT_WIDTH  LF bytes currently queued (optional feature)
- line_avail  out  1  line_count != 0 (optional feature)

Behaviour:
- Reset (async assert, sync deassert by upstream):
  - read/write pointers = 0, count = 0, full = 0, rd_valid = 0
  - overflow = 0, frame_err = 0, line_count = 0, line_avail = 0
  - rd_data = 0 when empty
  - storage contents are don't-care
- Push condition: uart_rx_valid && !uart_rx_err && (!full || pop).
  - On push, the byte is written at wr_ptr and wr_ptr increments.
- Pop condition: rd_valid && rd_ready; rd_ptr increments.
- rd_data is driven combinationally from mem[rd_ptr]; it is 0 when empty.
- Latency: a byte pushed at edge N is visible (rd_valid = 1, rd_data) after edge N, i.e. in cycle N+1.
  - A byte is never readable in the same cycle it arrives; there is no bypass.
- Simultaneous push and pop:
  - Non-empty: both happen and count is unchanged.
  - Full: push is accepted because the pop frees a slot; overflow is not set.
  - Empty: no pop is possible; the push proceeds normally.
- Error byte (uart_rx_valid && uart_rx_err): the byte is discarded and frame_err is set. Pointers are untouched.
- Full without pop: the incoming valid byte is discarded and overflow is set. Existing contents are preserved.
- Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. count is tracked separately to distinguish full from empty.
- clr_flags clears both sticky flags. If a set event occurs in the same cycle as clr_flags, the set wins.
- rd_ready while empty is ignored: no pointer movement, no underflow.
- Reset mid-stream empties the queue immediately. Any byte strobed during reset is lost.

Optional Feature:
- Macro: UART_RX_LINE_DETECT_EN
- Defined:
  - line_count increments when an 8'h0A byte is pushed and decrements when an 8'h0A byte is popped.
  - If both happen in the same cycle, line_count is unchanged.
  - line_avail = (line_count != 0). Dropped bytes (error or overflow) are never counted.
  - Software uses this to block until a full command line is buffered.
- Not defined: line_count and line_avail are tied to 0 and no counter logic is synthesized. Ports remain present.

Decomposition:
- Shared package uart_pkg holds:
  - UART_DATA_WIDTH-derived byte typedef (uart_byte_t)
  - the LF constant UART_LF = 8'h0A
  - default depth constant UART_RX_FIFO_DEPTH
  - a packed status struct {line_avail, full, frame_err, overflow, rd_valid} used by the MMIO status register
- Sub-module uart_fifo_mem holds the storage array: write-enable, write address/data, combinational read address/data.
  - It has no reset. Pointer, count and flag control stays in uart_rx_fifo.

Test Plan:
- Reset, then strobe 'A', 'q', 8'h0A one byte every 10 cycles with rd_ready = 0 -> count = 3, rd_data = 8'h41, rd_valid = 1. With the feature on: line_count = 1, line_avail = 1.
- Pop three times -> rd_data sequence 41, 71, 0A; then rd_valid = 0, count = 0, line_avail = 0; extra rd_ready causes no change.
- Push 17 bytes 8'h00..8'h10 with DEPTH = 16 and no pops -> full = 1, overflow = 1, count = 16. Popping yields 00..0F; 8'h10 is lost.
- With the queue full, push 8'h55 while popping in the same cycle -> overflow stays 0, count stays 16, and 8'h55 is the last byte popped.
- Strobe 8'h42 with uart_rx_err = 1 -> frame_err = 1, count unchanged. Pulse clr_flags -> frame_err = 0. A clr_flags pulse coincident with a new error -> frame_err = 1.
- Assert rst asynchronously mid-burst with count = 5 -> count = 0, rd_valid = 0, and flags = 0 immediately without waiting for a clock edge.
